// File: rtl/uart_byte_rx.sv
// uart_byte_rx
//   8N1 UART receiver, LSB first, idle-high line.
//
//   Parameters:
//     CLKS_PER_BIT - clk cycles per UART bit (4..65535)
//
//   Ports:
//     clk       - single clock, rising edge
//     rst       - synchronous active-high reset
//     rx        - asynchronous serial input
//     data      - last correctly framed byte, held until the next good byte
//     valid     - one-cycle pulse when data updates
//     frame_err - one-cycle pulse when the stop bit samples low
//     busy      - high whenever the receiver is not idle
module uart_byte_rx #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;
  logic             wait_high_q, wait_high_d;
  logic             rx_meta_q, rx_s_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;
    wait_high_d = wait_high_q;

    unique case (state_q)
      IDLE: begin
        // After a framing error the line may still be held low (break);
        // a new start is only accepted once the line has been seen high.
        if (wait_high_q) begin
          if (rx_s_q) wait_high_d = 1'b0;
        end else if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          // Return to IDLE at mid-stop-bit so a start bit that begins right
          // at the nominal stop-bit end is still caught.
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d      = 1'b1;
            wait_high_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
      wait_high_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      busy_q      <= busy_d;
      wait_high_q <= wait_high_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx
//   Scoreboarded bench for uart_byte_rx at 16 clocks per bit. Each frame
//   sent pushes its expected outcome (good byte or framing error with the
//   previously held byte); a monitor pops and compares on every pulse.
module tb_uart_byte_rx;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  model_good = 8'h00;
  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned both_cnt = 0;
  int unsigned long_pulse_cnt = 0;
  int unsigned data_glitch_cnt = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  // Expected outcome of a whole frame: a good stop bit delivers the byte,
  // a bad one reports an error and leaves the last good byte on data.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    exp_t e;
    if (stop_ok) begin
      e.is_err   = 1'b0;
      e.data     = b;
      model_good = b;
    end else begin
      e.is_err = 1'b1;
      e.data   = model_good;
    end
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok);
    rx = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || busy) && n < 4000) begin
      tick(1);
      n++;
    end
    tick(4);
    check(name, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx = 1'($urandom_range(0, 1));
      tick(1);
      check("reset_data", data, 8'h00);
      check("reset_pulses", {valid, frame_err, busy}, 0);
    end
    rx = 1'b1;
    tick(1);
    exp_q.delete();
    model_good = 8'h00;
    rst = 1'b0;
    tick(3);
  endtask

  // Monitor: samples 1 time unit after each active edge.
  initial begin
    exp_t       e;
    logic [7:0] prev_data  = 8'h00;
    bit         prev_pulse = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_data  = data;
        prev_pulse = 1'b0;
      end else begin
        if (valid && frame_err) both_cnt++;
        if ((valid || frame_err) && prev_pulse) long_pulse_cnt++;
        if (!valid && data != prev_data) data_glitch_cnt++;
        if (valid || frame_err) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_pulse: got valid=%0b frame_err=%0b data=%02h, required no pulse",
                     valid, frame_err, data);
          end else begin
            e = exp_q.pop_front();
            check("pulse_is_err", frame_err, e.is_err);
            check("pulse_data", data, e.data);
            check("pulse_busy", busy, 0);
          end
        end
        prev_pulse = valid || frame_err;
        prev_data  = data;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    bit         ok;
    logic [7:0] bits55;

    do_reset();

    // Single good byte
    send_frame(8'hA5, 1'b1);
    wait_drain("drain_a5");
    check("data_a5", data, 8'hA5);
    check("busy_after_a5", busy, 0);

    // Back-to-back frames
    send_frame(8'h3C, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_drain("drain_3c_ff");
    check("data_ff", data, 8'hFF);

    // Bad stop bit after reset
    do_reset();
    send_frame(8'h12, 1'b0);
    tick(8);
    wait_drain("drain_12");
    check("data_after_ferr", data, 8'h00);

    // Short glitch, then a real frame
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(30);
    check("busy_after_glitch", busy, 0);
    send_frame(8'h81, 1'b1);
    wait_drain("drain_81");
    check("data_81", data, 8'h81);

    // Reset in the middle of bit 4 of 0x55
    do_reset();
    bits55 = 8'h55;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(bits55[i]);
    rx = bits55[4];
    tick(CPB / 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rx  = 1'b1;
    tick(3 * CPB);
    check("data_after_abort", data, 8'h00);
    check("busy_after_abort", busy, 0);
    send_frame(8'h7E, 1'b1);
    wait_drain("drain_7e");
    check("data_7e", data, 8'h7E);

    // Break: line low for 20 bit times
    begin
      exp_t e;
      e.is_err = 1'b1;
      e.data   = model_good;
      exp_q.push_back(e);
    end
    rx = 1'b0;
    tick(20 * CPB);
    check("busy_during_break", busy, 0);
    check("break_err_seen", exp_q.size(), 0);
    rx = 1'b1;
    tick(2 * CPB);
    wait_drain("drain_break");
    check("data_after_break", data, 8'h7E);

    // Random frames with occasional bad stop bits and random gaps
    for (int n = 0; n < 30; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(b, ok);
      if (ok) tick($urandom_range(0, 40));
      else    tick($urandom_range(4, 40));
    end
    wait_drain("drain_random");
    check("data_random_final", data, model_good);

    check("valid_and_ferr_together", both_cnt, 0);
    check("pulse_longer_than_one", long_pulse_cnt, 0);
    check("data_changed_without_valid", data_glitch_cnt, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clk cycles per UART bit (12 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port rx, input, 1 bit: asynchronous serial line; idle high; 8N1 format, LSB first.
REQ-005 SHALL have port data, output, 8 bits: last correctly framed byte, held until the next good byte; drives the 8-bit hex-display input directly.
REQ-006 SHALL have port valid, output, 1 bit: one-cycle pulse when data updates.
REQ-007 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a stop bit samples low.
REQ-008 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer (rx_s); all FSM decisions use rx_s only.
REQ-010 SHALL implement FSM states IDLE, START, DATA, STOP with a bit-timing counter of ceil(log2(CLKS_PER_BIT)) bits and a 3-bit bit index.
REQ-011 IDLE: rx_s==0 -> START, counter cleared; otherwise remain in IDLE.
REQ-012 START: counts CLKS_PER_BIT/2 cycles (integer division); at the sample point rx_s==0 -> DATA, counter and bit index cleared; rx_s==1 -> IDLE (glitch reject; no valid, no frame_err).
REQ-013 DATA: samples rx_s every CLKS_PER_BIT cycles; shifts it into bit[index], LSB first; after index 7 -> STOP.
REQ-014 STOP: samples rx_s after CLKS_PER_BIT cycles; then -> IDLE immediately, at mid-stop-bit, so a start bit beginning at the nominal stop-bit end is caught.
REQ-015 Stop sample 1: data <= shift register and valid=1 in the cycle immediately after the sample.
REQ-016 Stop sample 0: frame_err=1 in the cycle immediately after the sample; data unchanged; valid stays 0.
REQ-017 valid and frame_err SHALL never be high together and SHALL each be high for exactly one cycle per event.
REQ-018 Counter SHALL reload to 0 at every sample point; no wrap beyond CLKS_PER_BIT-1.
REQ-019 A line held low continuously (break) SHALL yield frame_err once, then remain in IDLE until rx_s returns high before the next start detect.
REQ-020 data SHALL change only on a valid pulse or reset.

Reset
REQ-021 With rst high at a clk edge: state=IDLE, data=8'h00, valid=0, frame_err=0, busy=0, both synchronizer flops=1, counter=0, bit index=0, shift register=0.
REQ-022 rst mid-frame SHALL abort the frame with no valid or frame_err pulse; the next start bit after rst deasserts SHALL be received normally.
REQ-023 Outputs SHALL hold their reset values on every cycle rst is high, regardless of rx.

Verification (CLKS_PER_BIT=16)
REQ-024 Send 0xA5 with a good stop bit -> exactly one valid pulse, data=0xA5 from that cycle on, frame_err never high, busy low after the pulse.
REQ-025 Send 0x3C, then 0xFF back-to-back, each start bit immediately following the previous stop bit -> two valid pulses; data=0x3C, then 0xFF.
REQ-026 Send 0x12 with the stop bit forced low -> one frame_err pulse, no valid, data keeps its previous value (0x00 after reset).
REQ-027 Drive rx low for 5 cycles, then high -> FSM returns to IDLE from START, no valid or frame_err; a following 0x81 frame is received correctly.
REQ-028 Assert rst for 1 cycle during bit 4 of 0x55 -> no pulse for that frame, data=0x00; a subsequent 0x7E is received correctly, data=0x7E.
REQ-029 Hold rx low for 20 bit times, then high -> exactly one frame_err, no valid, and no further start detected until after rx returns high.
